// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - field layout, month/DIM constants, reset date and leap helper for the calendar date counter
package calendar_pkg;

    localparam int YEAR_W  = 14;
    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int DATE_W  = YEAR_W + MONTH_W + DAY_W;

    localparam int DAY_LSB   = 0;
    localparam int MONTH_LSB = DAY_LSB + DAY_W;
    localparam int YEAR_LSB  = MONTH_LSB + MONTH_W;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    localparam logic [DAY_W-1:0] DIM_LONG  = 5'd31;
    localparam logic [DAY_W-1:0] DIM_SHORT = 5'd30;
    localparam logic [DAY_W-1:0] DIM_LEAP  = 5'd29;
    localparam logic [DAY_W-1:0] DIM_FEB   = 5'd28;

    localparam int DEF_RST_YEAR  = 2000;
    localparam int DEF_RST_MONTH = 1;
    localparam int DEF_RST_DAY   = 1;
    localparam int DEF_YEAR_MAX  = 9999;

    // Gregorian rule: every 4th year, except centuries not divisible by 400
    function automatic logic is_leap(input logic [YEAR_W-1:0] year);
        return ((year % 14'd4) == 14'd0 && (year % 14'd100) != 14'd0) ||
               ((year % 14'd400) == 14'd0);
    endfunction

endpackage

// File: rtl/days_in_month.sv
// rtl/days_in_month.sv - combinational month length lookup including February leap handling
module days_in_month
    import calendar_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic [YEAR_W-1:0]  year,
    output logic [DAY_W-1:0]   dim
);

    // Out-of-range months fall to 31; callers check the month range themselves
    always_comb begin
        dim = DIM_LONG;
        case (month)
            FEB:                     dim = is_leap(year) ? DIM_LEAP : DIM_FEB;
            APR, JUN, SEP, NOV:      dim = DIM_SHORT;
            JAN, MAR, MAY, JUL, AUG,
            OCT, DEC:                dim = DIM_LONG;
            default:                 dim = DIM_LONG;
        endcase
    end

endmodule

// File: rtl/calendar_date_counter.sv
// rtl/calendar_date_counter.sv - registered calendar date counter with load validation; CAL_DECREMENT_EN adds day_tick_dn
module calendar_date_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_MAX  = DEF_YEAR_MAX,
    parameter int RST_YEAR  = DEF_RST_YEAR,
    parameter int RST_MONTH = DEF_RST_MONTH,
    parameter int RST_DAY   = DEF_RST_DAY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              day_tick,
`ifdef CAL_DECREMENT_EN
    input  logic              day_tick_dn,
`endif
    input  logic              load,
    input  logic [DATE_W-1:0] load_date,
    output logic [DATE_W-1:0] date,
    output logic              month_end,
    output logic              year_end,
    output logic              wrap,
    output logic              load_err
);

    localparam logic [YEAR_W-1:0]  YEAR_MAX_V = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0]  YEAR_ONE   = 14'd1;
    localparam logic [DAY_W-1:0]   DAY_ONE    = 5'd1;
    localparam logic [YEAR_W-1:0]  RST_Y      = YEAR_W'(RST_YEAR);
    localparam logic [MONTH_W-1:0] RST_M      = MONTH_W'(RST_MONTH);
    localparam logic [DAY_W-1:0]   RST_D      = DAY_W'(RST_DAY);

    logic [YEAR_W-1:0]  year_q, year_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [DAY_W-1:0]   day_q, day_d;
    logic               month_end_q, month_end_d;
    logic               year_end_q, year_end_d;
    logic               wrap_q, wrap_d;
    logic               load_err_q, load_err_d;

    logic [YEAR_W-1:0]  ld_year;
    logic [MONTH_W-1:0] ld_month;
    logic [DAY_W-1:0]   ld_day;
    logic [DAY_W-1:0]   dim_cur;
    logic [DAY_W-1:0]   dim_ld;
    logic               ld_valid;
    logic               fwd;

    assign ld_year  = load_date[YEAR_LSB  +: YEAR_W];
    assign ld_month = load_date[MONTH_LSB +: MONTH_W];
    assign ld_day   = load_date[DAY_LSB   +: DAY_W];

    days_in_month u_dim_cur (
        .month (month_q),
        .year  (year_q),
        .dim   (dim_cur)
    );

    days_in_month u_dim_ld (
        .month (ld_month),
        .year  (ld_year),
        .dim   (dim_ld)
    );

    assign ld_valid = (ld_year  >= YEAR_ONE) && (ld_year  <= YEAR_MAX_V) &&
                      (ld_month >= JAN)      && (ld_month <= DEC)        &&
                      (ld_day   >= DAY_ONE)  && (ld_day   <= dim_ld);

`ifdef CAL_DECREMENT_EN
    logic               bwd;
    logic [MONTH_W-1:0] prev_month;
    logic [YEAR_W-1:0]  prev_year;
    logic [DAY_W-1:0]   dim_prev;

    // Opposing ticks in the same cycle cancel out
    assign fwd        = day_tick & ~day_tick_dn;
    assign bwd        = day_tick_dn & ~day_tick;
    assign prev_month = (month_q == JAN) ? DEC : month_q - 4'd1;
    assign prev_year  = (month_q != JAN)   ? year_q     :
                        (year_q <= YEAR_ONE) ? YEAR_MAX_V : year_q - 14'd1;

    days_in_month u_dim_prev (
        .month (prev_month),
        .year  (prev_year),
        .dim   (dim_prev)
    );
`else
    assign fwd = day_tick;
`endif

    // Next-state: load wins over ticks; pulse flags default low every cycle
    always_comb begin
        year_d      = year_q;
        month_d     = month_q;
        day_d       = day_q;
        month_end_d = 1'b0;
        year_end_d  = 1'b0;
        wrap_d      = 1'b0;
        load_err_d  = 1'b0;
        if (load) begin
            if (ld_valid) begin
                year_d  = ld_year;
                month_d = ld_month;
                day_d   = ld_day;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (fwd) begin
            if (day_q < dim_cur) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d       = DAY_ONE;
                month_end_d = 1'b1;
                if (month_q < DEC) begin
                    month_d = month_q + 4'd1;
                end else begin
                    month_d    = JAN;
                    year_end_d = 1'b1;
                    if (year_q >= YEAR_MAX_V) begin
                        year_d = YEAR_ONE;
                        wrap_d = 1'b1;
                    end else begin
                        year_d = year_q + 14'd1;
                    end
                end
            end
        end
`ifdef CAL_DECREMENT_EN
        else if (bwd) begin
            if (day_q > DAY_ONE) begin
                day_d = day_q - 5'd1;
            end else begin
                day_d       = dim_prev;
                month_d     = prev_month;
                year_d      = prev_year;
                month_end_d = 1'b1;
                if (month_q == JAN) begin
                    year_end_d = 1'b1;
                    wrap_d     = (year_q <= YEAR_ONE);
                end
            end
        end
`endif
    end

    // State and pulse registers with asynchronous reset to the configured date
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            year_q      <= RST_Y;
            month_q     <= RST_M;
            day_q       <= RST_D;
            month_end_q <= 1'b0;
            year_end_q  <= 1'b0;
            wrap_q      <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            year_q      <= year_d;
            month_q     <= month_d;
            day_q       <= day_d;
            month_end_q <= month_end_d;
            year_end_q  <= year_end_d;
            wrap_q      <= wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    assign date      = {year_q, month_q, day_q};
    assign month_end = month_end_q;
    assign year_end  = year_end_q;
    assign wrap      = wrap_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// tb/tb_calendar_date_counter.sv - directed self-checking bench for calendar_date_counter
module tb_calendar_date_counter;

    logic        clk;
    logic        rst;
    logic        day_tick;
    logic        day_tick_dn;
    logic        load;
    logic [22:0] load_date;
    logic [22:0] date;
    logic        month_end;
    logic        year_end;
    logic        wrap;
    logic        load_err;

    int pass_cnt  = 0;
    int check_cnt = 0;

    calendar_date_counter dut (
        .clk         (clk),
        .rst         (rst),
        .day_tick    (day_tick),
`ifdef CAL_DECREMENT_EN
        .day_tick_dn (day_tick_dn),
`endif
        .load        (load),
        .load_date   (load_date),
        .date        (date),
        .month_end   (month_end),
        .year_end    (year_end),
        .wrap        (wrap),
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] mk(input int y, input int m, input int d);
        logic [13:0] yy;
        logic [3:0]  mm;
        logic [4:0]  dd;
        yy = 14'(y);
        mm = 4'(m);
        dd = 5'(d);
        return {yy, mm, dd};
    endfunction

    task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
    endtask

    task automatic check_flags(input string tag, input logic me, input logic ye,
                               input logic wr, input logic le);
        check(tag, {19'd0, month_end, year_end, wrap, load_err}, {19'd0, me, ye, wr, le});
    endtask

    // One clock edge with the given controls held across it; outputs sampled 1ns later
    task automatic cycle(input logic ld, input logic [22:0] ld_date, input logic tk, input logic tk_dn);
        load        = ld;
        load_date   = ld_date;
        day_tick    = tk;
        day_tick_dn = tk_dn;
        @(posedge clk);
        #1;
        load        = 1'b0;
        day_tick    = 1'b0;
        day_tick_dn = 1'b0;
    endtask

    int me_count;

    initial begin
        rst = 1'b0; load = 1'b0; load_date = '0; day_tick = 1'b0; day_tick_dn = 1'b0;
        @(posedge clk); #2;

        // Asynchronous reset with load and tick active
        rst = 1'b1; load = 1'b1; load_date = mk(2024, 6, 15); day_tick = 1'b1;
        #1;
        check("reset_date_async", date, 23'h0FA021);
        @(posedge clk); #1;
        check("reset_date_held", date, mk(2000, 1, 1));
        check_flags("reset_flags", 1'b0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; day_tick = 1'b0;
        #2 rst = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("idle_after_reset", date, mk(2000, 1, 1));

        // Leap year February
        cycle(1'b1, mk(2024, 2, 28), 1'b0, 1'b0);
        check("load_2024_02_28", date, mk(2024, 2, 28));
        check_flags("load_valid_flags", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("tick_2024_02_29", date, mk(2024, 2, 29));
        check_flags("no_month_end_feb28", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("tick_2024_03_01", date, mk(2024, 3, 1));
        check_flags("month_end_mar", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_flags("pulse_one_cycle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Non-leap February, 30-day month, non-leap century
        cycle(1'b1, mk(2023, 2, 28), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("tick_2023_03_01", date, mk(2023, 3, 1));
        cycle(1'b1, mk(2021, 4, 30), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("tick_2021_05_01", date, mk(2021, 5, 1));
        cycle(1'b1, mk(2100, 2, 28), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("tick_2100_03_01", date, mk(2100, 3, 1));

        // Load validation
        cycle(1'b1, mk(1900, 2, 29), 1'b0, 1'b0);
        check("bad_1900_02_29_date", date, mk(2100, 3, 1));
        check_flags("bad_1900_02_29_err", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_flags("load_err_one_cycle", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(2000, 2, 29), 1'b0, 1'b0);
        check("load_2000_02_29", date, mk(2000, 2, 29));
        check_flags("load_2000_02_29_ok", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(2020, 13, 1), 1'b0, 1'b0);
        check("bad_month13_date", date, mk(2000, 2, 29));
        check_flags("bad_month13_err", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, mk(2020, 5, 0), 1'b0, 1'b0);
        check_flags("bad_day0_err", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, mk(0, 5, 5), 1'b0, 1'b0);
        check_flags("bad_year0_err", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, mk(2021, 6, 31), 1'b0, 1'b0);
        check_flags("bad_jun31_err", 1'b0, 1'b0, 1'b0, 1'b1);
        check("bad_loads_date", date, mk(2000, 2, 29));

        // Year rollover and YEAR_MAX wrap
        cycle(1'b1, mk(2023, 12, 31), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("tick_2024_01_01", date, mk(2024, 1, 1));
        check_flags("year_end_flags", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, mk(9999, 12, 31), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("wrap_0001_01_01", date, mk(1, 1, 1));
        check_flags("wrap_flags", 1'b1, 1'b1, 1'b1, 1'b0);

        // Load beats tick, valid and invalid
        cycle(1'b1, mk(2021, 5, 10), 1'b1, 1'b0);
        check("load_over_tick", date, mk(2021, 5, 10));
        check_flags("load_over_tick_flags", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(2021, 2, 30), 1'b1, 1'b0);
        check("bad_load_drops_tick", date, mk(2021, 5, 10));
        check_flags("bad_load_tick_err", 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back ticks across a month boundary
        cycle(1'b1, mk(2021, 1, 1), 1'b0, 1'b0);
        me_count = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            if (month_end) me_count++;
        end
        check("run40_date", date, mk(2021, 2, 10));
        check("run40_month_end_cnt", 23'(me_count), 23'd1);

`ifdef CAL_DECREMENT_EN
        cycle(1'b1, mk(2024, 3, 1), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("dn_2024_02_29", date, mk(2024, 2, 29));
        check_flags("dn_month_end", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("both_ticks_hold", date, mk(2024, 2, 29));
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("dn_2024_02_28", date, mk(2024, 2, 28));
        cycle(1'b1, mk(2024, 1, 1), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("dn_2023_12_31", date, mk(2023, 12, 31));
        check_flags("dn_year_end", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, mk(1, 1, 1), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("dn_wrap_9999_12_31", date, mk(9999, 12, 31));
        check_flags("dn_wrap_flags", 1'b1, 1'b1, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
